// File: rtl/lab8_ctrl_pkg.sv
// Shared constants for the Lab8CA control sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the instruction opcode/funct encodings, the ALU_operation codes
// driven into the datapath, and the sequencer state encoding.
package lab8_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // R-type funct codes, IR[5:0]
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    // ALU_operation codes
    localparam logic [4:0] ALU_AND = 5'd0;
    localparam logic [4:0] ALU_OR  = 5'd1;
    localparam logic [4:0] ALU_XOR = 5'd2;
    localparam logic [4:0] ALU_NOR = 5'd3;
    localparam logic [4:0] ALU_ADD = 5'd4;
    localparam logic [4:0] ALU_SUB = 5'd5;
    localparam logic [4:0] ALU_SLT = 5'd6;
    localparam logic [4:0] ALU_SLL = 5'd7;
    localparam logic [4:0] ALU_SRL = 5'd8;

endpackage

// File: rtl/lab8_alu_decode.sv
// R-type funct decoder: maps funct to an ALU_operation code plus a legal flag.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   funct_i   R-type funct field IR[5:0]
//   alu_op_o  ALU_operation code for that funct (ALU_AND when illegal)
//   legal_o   1 when funct is one of the supported R-type operations
module lab8_alu_decode
    import lab8_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [4:0] alu_op_o,
    output logic       legal_o
);

    always_comb begin
        alu_op_o = ALU_AND;
        legal_o  = 1'b1;
        case (funct_i)
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_XOR:  alu_op_o = ALU_XOR;
            FN_NOR:  alu_op_o = ALU_NOR;
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_SLT:  alu_op_o = ALU_SLT;
            FN_SLL:  alu_op_o = ALU_SLL;
            FN_SRL:  alu_op_o = ALU_SRL;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/lab8_control_fsm.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) for the Lab8CA datapath.
// Latency: FETCH to next FETCH is 3 cycles (BEQ), 4 (R-type/ADDI/SW), 5 (LW).
// Backpressure: MEM stalls while mem_ready is low; each stalled cycle adds one.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   instr             instruction-memory data, captured into IR on leaving FETCH
//   zero              ALU zero flag, decides the BEQ PC load in EXEC
//   mem_ready         data-memory access complete, only looked at in MEM
//   RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg
//                     datapath controls
//   pc_write, ir_write  PC / IR load strobes
//   busy, halted, illegal, instr_count  status
module lab8_control_fsm
    import lab8_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             RegWrite,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic [4:0]       ALU_operation,
    output logic             write,
    output logic             MemtoReg,
    output logic             pc_write,
    output logic             ir_write,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e            state_q, state_d;
    logic [31:0]       ir_q;
    logic [CNT_W-1:0]  count_q;
    logic              illegal_q;

    logic              regwrite_q, pcsrc_q, alusrc_q, write_q, memtoreg_q;
    logic [4:0]        alu_op_q;
    logic              pc_write_q, ir_write_q, busy_q, halted_q;

    // Register/immediate fields belong to the datapath, not the sequencer.
    logic              ir_unused;
    assign ir_unused = ^ir_q[25:6];

    // ------------------------------------------------------------------
    // Instruction decode from the latched IR
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rtype_alu_op;
    logic       funct_legal;
    logic       is_rtype, is_lw, is_sw, is_beq, is_addi, is_halt;
    logic       instr_legal;
    logic [4:0] exec_alu_op;
    logic       exec_alusrc;
    logic       retire;

    assign opcode = ir_q[31:26];

    lab8_alu_decode u_alu_decode (
        .funct_i  (ir_q[5:0]),
        .alu_op_o (rtype_alu_op),
        .legal_o  (funct_legal)
    );

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_halt  = (opcode == OP_HALT);

    // An R-type opcode is only legal with a supported funct.
    assign instr_legal = (is_rtype && funct_legal) || is_lw || is_sw
                       || is_beq || is_addi || is_halt;

    assign exec_alu_op = is_rtype ? rtype_alu_op :
                         is_beq   ? ALU_SUB      : ALU_ADD;
    assign exec_alusrc = is_addi || is_lw || is_sw;

    // Transitions that complete an instruction back into FETCH.
    assign retire = (state_q == ST_WB)
                 || (state_q == ST_MEM  && is_sw && mem_ready)
                 || (state_q == ST_EXEC && is_beq);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (is_halt || !instr_legal) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (is_beq)              state_d = ST_FETCH;
                else if (is_lw || is_sw) state_d = ST_MEM;
                else                     state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready) state_d = is_sw ? ST_FETCH : ST_WB;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, IR, status and registered outputs. Outputs are computed from
    // the state being entered so they are valid for the whole of that state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            count_q    <= '0;
            illegal_q  <= 1'b0;
            regwrite_q <= 1'b0;
            pcsrc_q    <= 1'b0;
            alusrc_q   <= 1'b0;
            alu_op_q   <= '0;
            write_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            pc_write_q <= 1'b0;
            ir_write_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_FETCH) ir_q <= instr;
            if (state_q == ST_DECODE && !instr_legal) illegal_q <= 1'b1;
            if (retire) count_q <= count_q + CNT_W'(1);

            ir_write_q <= (state_d == ST_FETCH);
            pc_write_q <= (state_d == ST_FETCH);
            pcsrc_q    <= (state_d == ST_EXEC) && is_beq;
            write_q    <= (state_d == ST_MEM)  && is_sw;
            memtoreg_q <= (state_d == ST_MEM || state_d == ST_WB) && is_lw;
            regwrite_q <= (state_d == ST_WB);
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_HALT);
            halted_q   <= (state_d == ST_HALT);

            // ALU controls hold their EXEC value through MEM and WB.
            if (state_d == ST_EXEC || state_d == ST_MEM || state_d == ST_WB) begin
                alu_op_q <= exec_alu_op;
                alusrc_q <= exec_alusrc;
            end else begin
                alu_op_q <= '0;
                alusrc_q <= 1'b0;
            end
        end
    end

    assign RegWrite      = regwrite_q;
    assign PCSrc         = pcsrc_q;
    assign ALUSrc        = alusrc_q;
    assign ALU_operation = alu_op_q;
    assign write         = write_q;
    assign MemtoReg      = memtoreg_q;
    // The BEQ PC load follows zero combinationally while in EXEC.
    assign pc_write      = pc_write_q || (state_q == ST_EXEC && is_beq && zero);
    assign ir_write      = ir_write_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_lab8_control_fsm.sv
// Directed testbench for lab8_control_fsm; a second instance with CNT_W=2
// shares the stimulus so the counter wrap is visible in a short run.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_lab8_control_fsm;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [31:0] instr     = '0;
    logic        zero      = 1'b0;
    logic        mem_ready = 1'b0;

    logic        RegWrite, PCSrc, ALUSrc, write, MemtoReg;
    logic [4:0]  ALU_operation;
    logic        pc_write, ir_write, busy, halted, illegal;
    logic [15:0] instr_count;

    logic        RegWrite2, PCSrc2, ALUSrc2, write2, MemtoReg2;
    logic [4:0]  ALU_operation2;
    logic        pc_write2, ir_write2, busy2, halted2, illegal2;
    logic [1:0]  instr_count2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lab8_control_fsm #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ALU_operation(ALU_operation),
        .write(write), .MemtoReg(MemtoReg), .pc_write(pc_write), .ir_write(ir_write),
        .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    lab8_control_fsm #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .RegWrite(RegWrite2), .PCSrc(PCSrc2), .ALUSrc(ALUSrc2), .ALU_operation(ALU_operation2),
        .write(write2), .MemtoReg(MemtoReg2), .pc_write(pc_write2), .ir_write(ir_write2),
        .busy(busy2), .halted(halted2), .illegal(illegal2), .instr_count(instr_count2)
    );

    // {RegWrite, PCSrc, ALUSrc, ALU_operation[4:0], write, MemtoReg,
    //  pc_write, ir_write, busy, halted, illegal}
    logic [14:0] ctl, ctl2;
    assign ctl  = {RegWrite, PCSrc, ALUSrc, ALU_operation, write, MemtoReg,
                   pc_write, ir_write, busy, halted, illegal};
    assign ctl2 = {RegWrite2, PCSrc2, ALUSrc2, ALU_operation2, write2, MemtoReg2,
                   pc_write2, ir_write2, busy2, halted2, illegal2};

    localparam logic [14:0] C_IDLE     = 15'd0;
    localparam logic [14:0] C_F        = {3'b000, 5'd0, 7'b0011100};
    localparam logic [14:0] C_D        = {3'b000, 5'd0, 7'b0000100};
    localparam logic [14:0] C_E_ADD    = {3'b000, 5'd4, 7'b0000100};
    localparam logic [14:0] C_W_ADD    = {3'b100, 5'd4, 7'b0000100};
    localparam logic [14:0] C_E_SUB    = {3'b000, 5'd5, 7'b0000100};
    localparam logic [14:0] C_W_SUB    = {3'b100, 5'd5, 7'b0000100};
    localparam logic [14:0] C_E_MEM    = {3'b001, 5'd4, 7'b0000100};
    localparam logic [14:0] C_M_LW     = {3'b001, 5'd4, 7'b0100100};
    localparam logic [14:0] C_M_SW     = {3'b001, 5'd4, 7'b1000100};
    localparam logic [14:0] C_W_LW     = {3'b101, 5'd4, 7'b0100100};
    localparam logic [14:0] C_E_BEQ_T  = {3'b010, 5'd5, 7'b0010100};
    localparam logic [14:0] C_E_BEQ_N  = {3'b010, 5'd5, 7'b0000100};
    localparam logic [14:0] C_HALT     = {3'b000, 5'd0, 7'b0000010};
    localparam logic [14:0] C_HALT_ILL = {3'b000, 5'd0, 7'b0000011};

    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    task automatic tick();
        @(negedge clk);
    endtask

    // Reset for one edge, release, and step into FETCH.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        vectors++;
        if (ctl !== C_IDLE || ctl2 !== C_IDLE) begin
            $display("FAIL reset_edge1: ctl %h/%h want %h", ctl, ctl2, C_IDLE); miscompares++;
        end
        tick();
        vectors++;
        if (ctl !== C_IDLE || ctl2 !== C_IDLE || instr_count !== 16'd0 || instr_count2 !== 2'd0) begin
            $display("FAIL reset_edge2: ctl %h/%h cnt %0d/%0d want %h cnt 0/0",
                     ctl, ctl2, instr_count, instr_count2, C_IDLE); miscompares++;
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (ctl !== C_F || ctl2 !== C_F) begin
            $display("FAIL reset_to_fetch: ctl %h/%h want %h", ctl, ctl2, C_F); miscompares++;
        end
    endtask

    task automatic test_rtype();
        logic [14:0] exp [2][4];
        logic [31:0] ins [2];
        exp = '{'{C_D, C_E_ADD, C_W_ADD, C_F}, '{C_D, C_E_SUB, C_W_SUB, C_F}};
        ins = '{32'h012A_4020, 32'h012A_4022};
        for (int i = 0; i < 2; i++) begin
            instr = ins[i];
            for (int c = 0; c < 4; c++) begin
                tick();
                if (c == 0) instr = I_HALT;   // IR must already hold the instruction
                vectors++;
                if (ctl !== exp[i][c] || ctl2 !== exp[i][c]) begin
                    $display("FAIL rtype%0d_cyc%0d: ctl %h/%h want %h", i, c, ctl, ctl2, exp[i][c]);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (instr_count !== 16'd2 || instr_count2 !== 2'd2) begin
            $display("FAIL rtype_count: cnt %0d/%0d want 2/2", instr_count, instr_count2); miscompares++;
        end
    endtask

    task automatic test_rtype_map();
        logic [5:0] fn [7];
        logic [4:0] op [7];
        logic [14:0] e_exec, e_wb;
        fn = '{6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000000, 6'b000010};
        op = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7, 5'd8};
        for (int i = 0; i < 7; i++) begin
            e_exec = {3'b000, op[i], 7'b0000100};
            e_wb   = {3'b100, op[i], 7'b0000100};
            instr  = 32'h012A_4000 | {26'd0, fn[i]};
            tick();
            instr = I_HALT;
            tick();
            vectors++;
            if (ctl !== e_exec || ctl2 !== e_exec) begin
                $display("FAIL funct_%b_exec: ctl %h/%h want %h", fn[i], ctl, ctl2, e_exec); miscompares++;
            end
            tick();
            vectors++;
            if (ctl !== e_wb || ctl2 !== e_wb) begin
                $display("FAIL funct_%b_wb: ctl %h/%h want %h", fn[i], ctl, ctl2, e_wb); miscompares++;
            end
            tick();
        end
        vectors++;
        if (instr_count !== 16'd9 || instr_count2 !== 2'd1) begin
            $display("FAIL rtype_map_count: cnt %0d/%0d want 9/1", instr_count, instr_count2); miscompares++;
        end
    endtask

    task automatic test_lw_stall();
        logic [14:0] exp [7];
        exp = '{C_D, C_E_MEM, C_M_LW, C_M_LW, C_M_LW, C_W_LW, C_F};
        instr = 32'h8C08_0004;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) instr = I_HALT;
            vectors++;
            if (ctl !== exp[c] || ctl2 !== exp[c]) begin
                $display("FAIL lw_cyc%0d: ctl %h/%h want %h", c, ctl, ctl2, exp[c]); miscompares++;
            end
            mem_ready = (c == 4);
        end
        vectors++;
        if (instr_count !== 16'd10 || instr_count2 !== 2'd2) begin
            $display("FAIL lw_count: cnt %0d/%0d want 10/2", instr_count, instr_count2); miscompares++;
        end
    endtask

    task automatic test_sw_stall();
        logic [14:0] exp [6];
        exp = '{C_D, C_E_MEM, C_M_SW, C_M_SW, C_M_SW, C_F};
        instr = 32'hAD09_0008;
        mem_ready = 1'b1;   // high outside MEM must have no effect
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) instr = I_HALT;
            vectors++;
            if (ctl !== exp[c] || ctl2 !== exp[c]) begin
                $display("FAIL sw_cyc%0d: ctl %h/%h want %h", c, ctl, ctl2, exp[c]); miscompares++;
            end
            mem_ready = (c != 2) && (c != 3);
        end
        mem_ready = 1'b0;
        vectors++;
        if (instr_count !== 16'd11 || instr_count2 !== 2'd3) begin
            $display("FAIL sw_count: cnt %0d/%0d want 11/3", instr_count, instr_count2); miscompares++;
        end
    endtask

    task automatic test_beq();
        logic [14:0] exp [2][3];
        exp = '{'{C_D, C_E_BEQ_T, C_F}, '{C_D, C_E_BEQ_N, C_F}};
        for (int i = 0; i < 2; i++) begin
            instr = 32'h1109_0003;
            zero  = (i == 0);
            for (int c = 0; c < 3; c++) begin
                tick();
                if (c == 0) instr = I_HALT;
                vectors++;
                if (ctl !== exp[i][c] || ctl2 !== exp[i][c]) begin
                    $display("FAIL beq%0d_cyc%0d: ctl %h/%h want %h", i, c, ctl, ctl2, exp[i][c]);
                    miscompares++;
                end
            end
        end
        zero = 1'b0;
        vectors++;
        if (instr_count !== 16'd13 || instr_count2 !== 2'd1) begin
            $display("FAIL beq_count: cnt %0d/%0d want 13/1", instr_count, instr_count2); miscompares++;
        end
    endtask

    task automatic test_halt();
        instr = I_HALT;
        tick();
        vectors++;
        if (ctl !== C_D || ctl2 !== C_D) begin
            $display("FAIL halt_decode: ctl %h/%h want %h", ctl, ctl2, C_D); miscompares++;
        end
        zero = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (ctl !== C_HALT || ctl2 !== C_HALT || instr_count !== 16'd13 || instr_count2 !== 2'd1) begin
                $display("FAIL halt_hold%0d: ctl %h/%h cnt %0d/%0d want %h cnt 13/1",
                         c, ctl, ctl2, instr_count, instr_count2, C_HALT); miscompares++;
            end
        end
        zero = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        ins = '{32'h5400_0000, 32'h012A_403F};   // bad opcode, bad R-type funct
        for (int i = 0; i < 2; i++) begin
            do_reset();
            instr = ins[i];
            tick();
            instr = I_HALT;
            for (int c = 0; c < 3; c++) begin
                tick();
                vectors++;
                if (ctl !== C_HALT_ILL || ctl2 !== C_HALT_ILL) begin
                    $display("FAIL illegal%0d_hold%0d: ctl %h/%h want %h", i, c, ctl, ctl2, C_HALT_ILL);
                    miscompares++;
                end
            end
            reset = 1'b1;
            tick();
            vectors++;
            if (ctl !== C_IDLE || ctl2 !== C_IDLE) begin
                $display("FAIL illegal%0d_cleared: ctl %h/%h want %h", i, ctl, ctl2, C_IDLE); miscompares++;
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sw();
        instr = 32'h012A_4020;
        for (int c = 0; c < 4; c++) tick();
        vectors++;
        if (instr_count !== 16'd1 || instr_count2 !== 2'd1) begin
            $display("FAIL midsw_pre_count: cnt %0d/%0d want 1/1", instr_count, instr_count2); miscompares++;
        end
        instr = 32'hAD09_0008;
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();   // DECODE, EXEC, MEM, MEM
        vectors++;
        if (ctl !== C_M_SW || ctl2 !== C_M_SW) begin
            $display("FAIL midsw_stalled: ctl %h/%h want %h", ctl, ctl2, C_M_SW); miscompares++;
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (ctl !== C_IDLE || ctl2 !== C_IDLE || instr_count !== 16'd0 || instr_count2 !== 2'd0) begin
            $display("FAIL midsw_abort: ctl %h/%h cnt %0d/%0d want %h cnt 0/0",
                     ctl, ctl2, instr_count, instr_count2, C_IDLE); miscompares++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            instr = 32'h1109_0003;
            for (int c = 0; c < 3; c++) tick();
        end
        vectors++;
        if (instr_count !== 16'd5 || instr_count2 !== 2'd1) begin
            $display("FAIL wrap_count: cnt %0d/%0d want 5/1", instr_count, instr_count2); miscompares++;
        end
        // Reset on the WB->FETCH edge must win over the increment.
        instr = 32'h012A_4020;
        for (int c = 0; c < 3; c++) tick();
        vectors++;
        if (ctl !== C_W_ADD || ctl2 !== C_W_ADD) begin
            $display("FAIL wrap_wb: ctl %h/%h want %h", ctl, ctl2, C_W_ADD); miscompares++;
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (instr_count !== 16'd0 || instr_count2 !== 2'd0 || ctl !== C_IDLE) begin
            $display("FAIL reset_beats_retire: cnt %0d/%0d ctl %h want 0/0 %h",
                     instr_count, instr_count2, ctl, C_IDLE); miscompares++;
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_rtype_map();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_halt();
        test_illegal();
        test_reset_mid_sw();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lab8_control_fsm.md
# lab8_control_fsm

Multi-cycle control sequencer for the Lab8CA datapath. It latches each instruction fetched from instruction memory, decodes opcode and funct, and walks a FETCH/DECODE/EXEC/MEM/WB state machine. In each state it drives the datapath control inputs: RegWrite, PCSrc, ALUSrc, ALU_operation, write and MemtoReg. It also provides PC/IR strobes, a data-memory ready handshake, halt/illegal status and a retired-instruction counter. It replaces the hand-driven control stimulus used today.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction-memory read data at current PC.
- zero  in  1  ALU zero flag from datapath.
- mem_ready  in  1  data memory has completed the current access.
- RegWrite  out  1  register-file write enable.
- PCSrc  out  1  0 = PC+4, 1 = branch target.
- ALUSrc  out  1  0 = register operand, 1 = sign-extended immediate.
- ALU_operation  out  5  ALU function select.
- write  out  1  data-memory write enable.
- MemtoReg  out  1  1 = write-back from memory, 0 = from ALU.
- pc_write  out  1  PC load strobe.
- ir_write  out  1  IR load strobe; the internal IR captures instr on the same edge.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on an undecodable instruction.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.

Opcodes are taken from IR[31:26]:
- R-type 000000
- LW 100011
- SW 101011
- BEQ 000100
- ADDI 001000
- HALT 111111

ALU_operation codes:
- AND=0, OR=1, XOR=2, NOR=3, ADD=4, SUB=5, SLT=6, SLL=7, SRL=8.

R-type funct map:
- 100100→AND, 100101→OR, 100110→XOR, 100111→NOR.
- 100000→ADD, 100010→SUB, 101010→SLT.
- 000000→SLL, 000010→SRL.
- Any other funct is illegal.

State behaviour and transitions:
- IDLE: all outputs 0. Goes to FETCH on the next cycle.
- FETCH: ir_write=1 and pc_write=1 with PCSrc=0. Goes to DECODE.
- DECODE: outputs 0.
  - HALT opcode → HALT.
  - Unknown opcode or funct → HALT with illegal set.
  - Otherwise → EXEC.
- EXEC:
  - ALU_operation and ALUSrc are driven from the IR: R-type uses the funct map, ALUSrc=0; ADDI/LW/SW use ADD, ALUSrc=1; BEQ uses SUB, ALUSrc=0.
  - R-type/ADDI → WB; LW/SW → MEM.
  - BEQ: PCSrc=1, pc_write=zero (the only combinational input path), then → FETCH.
- MEM:
  - SW holds write=1; LW holds MemtoReg=1.
  - Stays in MEM while mem_ready=0.
  - When mem_ready=1: SW → FETCH, LW → WB.
- WB: RegWrite=1; MemtoReg=1 only for LW. Goes to FETCH.
- HALT: all datapath controls 0 and halted=1. Exited only by reset.

Output holding and counter:
- ALU_operation and ALUSrc hold their EXEC value through MEM and WB. They are 0 in IDLE, FETCH, DECODE and HALT.
- instr_count increments on each retiring transition: WB→FETCH, MEM→FETCH for SW, and EXEC→FETCH for BEQ. HALT and illegal instructions do not count.

## Timing
- Reset:
  - reset=1 at an edge puts the block in IDLE.
  - IR, instr_count and illegal are cleared to 0.
  - All outputs are 0 in the cycle after that edge.
  - reset mid-instruction (including during a stalled MEM write) aborts it; write and RegWrite are low from the next cycle.
- Minimum latency, FETCH to the next FETCH:
  - BEQ 3 cycles.
  - R-type/ADDI/SW 4 cycles.
  - LW 5 cycles.
  - Each cycle with mem_ready=0 in MEM adds one cycle.
- Handshake and data capture:
  - mem_ready is sampled only in MEM; it is ignored elsewhere.
  - write stays asserted for every cycle spent in MEM.
  - instr must be valid during FETCH; it is captured at the FETCH→DECODE edge.
- Counter wrap: instr_count goes from 2^CNT_W−1 to 0 with no flag.
- Simultaneous events: reset overrides every transition, including a counter increment on the same edge.

## Structure
- Package lab8_ctrl_pkg holds the opcode and funct constants, ALU_operation codes and the state encoding.
- Sub-module lab8_alu_decode: combinational funct → {ALU_operation, legal}.
- The top module holds the FSM, the IR and the counter.

## Test plan
- Reset, then idle: with reset held 2 cycles, all outputs are 0. After release: IDLE for 1 cycle, then FETCH with pc_write=1 and ir_write=1.
- R-type ADD then SUB:
  - ADD instr=0x012A4020: EXEC shows ALU_operation=4, ALUSrc=0. WB shows RegWrite=1, MemtoReg=0. 4 cycles total.
  - SUB (funct 100010) shows ALU_operation=5.
  - instr_count=2.
- LW with stall:
  - instr=0x8C080004, mem_ready low for 2 MEM cycles: MEM lasts 3 cycles with MemtoReg=1, ALU_operation=4, ALUSrc=1, write=0.
  - WB shows RegWrite=1, MemtoReg=1; 7 cycles total.
  - SW with the same stall holds write=1 for all 3 MEM cycles and never asserts RegWrite.
- BEQ taken and not taken:
  - opcode 000100 with zero=1: EXEC shows pc_write=1, PCSrc=1, ALU_operation=5.
  - With zero=0: pc_write=0.
  - Both take 3 cycles and each increments instr_count.
- HALT and illegal:
  - 0xFC000000: HALT, halted=1, busy=0, instr_count unchanged.
  - Opcode 010101: HALT with illegal=1, which stays set until reset.
- Reset mid-SW and counter wrap:
  - reset asserted during a stalled MEM: write=0 the next cycle, instr_count=0.
  - With CNT_W=2, five retired instructions give instr_count=1.
